// File: rtl/i2c_tgt2202_pkg.sv
// i2c_pkg2202: shared state names, default target address and synchronizer depth.
package i2c_pkg2202;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_AACK, ST_WDATA, ST_WACK, ST_RDATA, ST_RACK, ST_WAIT
  } state_e;
  localparam logic [6:0] TGT_ADDR = 7'h42;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/i2c_tgt2202_if.sv
// i2c_tgt2202_if: bus lines plus byte-stream handshake between target and its environment.
interface i2c_tgt2202_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda_oe;
  logic       o_busy;
  logic       o_rx_valid;
  logic [7:0] o_rx_data;
  logic       o_tx_req;
  logic [7:0] i_tx_data;
  modport slave (input i_scl, i_sda, i_tx_data, output o_sda_oe, o_busy, o_rx_valid, o_rx_data, o_tx_req);
  modport master (output i_scl, i_sda, i_tx_data, input o_sda_oe, o_busy, o_rx_valid, o_rx_data, o_tx_req);
endinterface

// File: rtl/i2c_tgt2202_sync.sv
// i2c_sync_edge2202: synchronizes one bus line and flags its rising/falling edges.
module i2c_sync_edge2202
  import i2c_pkg2202::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic line_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  hist_q;
  // idle bus level is high, so reset there to avoid phantom edges
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], line_i};
      hist_q <= sync_q[SYNC_DEPTH-1];
    end
  end
  assign lvl_o  = sync_q[SYNC_DEPTH-1];
  assign rise_o = lvl_o & ~hist_q;
  assign fall_o = ~lvl_o & hist_q;
endmodule

// File: rtl/i2c_tgt2202.sv
// i2c_tgt2202: oversampling I2C target with address match, ACK and byte-stream data.
module i2c_tgt2202
  import i2c_pkg2202::*;
#(
  parameter logic [6:0] ADDR = TGT_ADDR
) (
  input logic           i_clk,
  input logic           i_rst,
  i2c_tgt2202_if.slave  bus
);
  logic scl, scl_r, scl_f, sda, sda_r, sda_f;
  i2c_sync_edge2202 u_scl (.i_clk, .i_rst, .line_i(bus.i_scl), .lvl_o(scl), .rise_o(scl_r), .fall_o(scl_f));
  i2c_sync_edge2202 u_sda (.i_clk, .i_rst, .line_i(bus.i_sda), .lvl_o(sda), .rise_o(sda_r), .fall_o(sda_f));
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, rx_data_q, rx_data_d, sh_in;
  logic       rw_q, rw_d, ph_q, ph_d, oe_q, oe_d, busy_q, busy_d, rxv_q, rxv_d, txr_q, txr_d;
  logic       start_w, stop_w, last, hit;
  // an SCL edge in the same sample masks any START/STOP decode
  assign start_w = scl & sda_f & ~scl_r & ~scl_f;
  assign stop_w  = scl & sda_r & ~scl_r & ~scl_f;
  assign sh_in   = {sh_q[6:0], sda};
  assign last    = cnt_q == 3'd7;
  assign hit     = sh_in[7:1] == ADDR;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rx_data_d = rx_data_q;
    rw_d      = rw_q;
    ph_d      = ph_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rxv_d     = 1'b0;
    txr_d     = 1'b0;
    if (txr_q) begin
      sh_d = bus.i_tx_data;
      oe_d = ~bus.i_tx_data[7];
    end
    if (start_w) begin
      state_d = ST_ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      ph_d    = 1'b0;
    end else if (stop_w) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      ph_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_r) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 3'd1;
          if (last) begin
            state_d = hit ? ST_AACK : ST_WAIT;
            busy_d  = hit;
            rw_d    = sda;
            ph_d    = 1'b0;
          end
        end
        // ph_q: 0 = waiting to drive ACK, 1 = ACK on bus until the next fall
        ST_AACK, ST_WACK: if (scl_f) begin
          ph_d = ~ph_q;
          oe_d = ~ph_q;
          if (ph_q) begin
            state_d = rw_q ? ST_RDATA : ST_WDATA;
            txr_d   = rw_q;
            cnt_d   = 3'd0;
          end
        end
        ST_WDATA: if (scl_r) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 3'd1;
          if (last) begin
            rx_data_d = sh_in;
            rxv_d     = 1'b1;
            state_d   = ST_WACK;
            ph_d      = 1'b0;
          end
        end
        ST_RDATA: if (scl_f) begin
          cnt_d   = cnt_q + 3'd1;
          sh_d    = {sh_q[6:0], 1'b0};
          oe_d    = last ? 1'b0 : ~sh_q[6];
          state_d = last ? ST_RACK : ST_RDATA;
          ph_d    = 1'b0;
        end
        ST_RACK: if (scl_r && !ph_q) begin
          ph_d    = ~sda;
          state_d = sda ? ST_WAIT : ST_RACK;
        end else if (scl_f && ph_q) begin
          state_d = ST_RDATA;
          txr_d   = 1'b1;
          cnt_d   = 3'd0;
          ph_d    = 1'b0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      sh_q      <= 8'h00;
      rx_data_q <= 8'h00;
      rw_q      <= 1'b0;
      ph_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rxv_q     <= 1'b0;
      txr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rx_data_q <= rx_data_d;
      rw_q      <= rw_d;
      ph_q      <= ph_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rxv_q     <= rxv_d;
      txr_q     <= txr_d;
    end
  end
  // first read bit goes out in the tx_req cycle, straight from the offered byte
  assign bus.o_sda_oe   = txr_q ? ~bus.i_tx_data[7] : oe_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_rx_valid = rxv_q;
  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_tx_req   = txr_q;
endmodule

// File: tb/tb_i2c_tgt2202.sv
// tb_i2c_tgt2202: bus-master driven scoreboard bench for the I2C target.
module tb_i2c_tgt2202;
  localparam logic [6:0] TGT = 7'h42;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  int pass_n = 0;
  int total_n = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_src[$];
  logic [7:0] rd_exp[$];
  i2c_tgt2202_if bus();
  assign bus.i_scl     = m_scl;
  assign bus.i_sda     = m_sda & ~bus.o_sda_oe;
  assign bus.i_tx_data = tx_data;
  i2c_tgt2202 dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    cyc(4); m_sda = b; cyc(4); m_scl = 1'b1; cyc(8); m_scl = 1'b0;
  endtask
  task automatic recv_bit(output logic b);
    cyc(4); m_sda = 1'b1; cyc(4); m_scl = 1'b1; cyc(4); b = bus.i_sda; cyc(4); m_scl = 1'b0;
  endtask
  task automatic start_c();
    if (!m_scl) begin
      cyc(4); m_sda = 1'b1; cyc(4); m_scl = 1'b1;
    end
    cyc(8); m_sda = 1'b0; cyc(8); m_scl = 1'b0;
  endtask
  task automatic stop_c();
    cyc(4); m_sda = 1'b0; cyc(4); m_scl = 1'b1; cyc(8); m_sda = 1'b1; cyc(8);
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bit_v);
      b[i] = bit_v;
    end
    send_bit(nack);
  endtask
  // reference: only TGT is answered; writes land on rx in order, reads return offered bytes
  task automatic xfer(input logic [6:0] a, input logic rw, input int n,
                      input logic [7:0] d0, input logic [7:0] d1, input logic do_stop);
    logic m, ack;
    logic [7:0] b;
    m = (a == TGT);
    if (rw && m)
      for (int i = 0; i < n; i++) begin
        b = (i == 0) ? d0 : (i == 1) ? d1 : 8'($urandom);
        tx_src.push_back(b);
        rd_exp.push_back(b);
      end
    start_c();
    write_byte({a, rw}, ack);
    chk("addr_ack", ack, !m);
    chk("busy_after_addr", bus.o_busy, m);
    for (int i = 0; i < n; i++) begin
      if (!rw) begin
        b = (i == 0) ? d0 : (i == 1) ? d1 : 8'($urandom);
        if (m) rx_exp.push_back(b);
        write_byte(b, ack);
        chk("data_ack", ack, !m);
      end else begin
        read_byte(i == n - 1, b);
        chk("rd_data", b, m ? rd_exp.pop_front() : 8'hFF);
      end
    end
    if (do_stop) begin
      stop_c();
      chk("busy_after_stop", bus.o_busy, 0);
      chk("oe_idle", bus.o_sda_oe, 0);
      chk("rx_drained", rx_exp.size(), 0);
      chk("tx_drained", tx_src.size(), 0);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_rx_valid) begin
        chk("rx_expected", rx_exp.size() > 0, 1);
        if (rx_exp.size() > 0) chk("rx_data", bus.o_rx_data, rx_exp.pop_front());
      end
      if (bus.o_tx_req) begin
        chk("tx_req_expected", tx_src.size() > 0, 1);
        if (tx_src.size() > 0) void'(tx_src.pop_front());
      end else tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
    end
  end
  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic ack;
    logic [6:0] a;
    cyc(4);
    rst = 1'b0;
    cyc(2);
    chk("rst_oe", bus.o_sda_oe, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_rxv", bus.o_rx_valid, 0);
    chk("rst_txr", bus.o_tx_req, 0);
    chk("rst_rxd", bus.o_rx_data, 0);
    cyc(8);
    xfer(TGT, 1'b0, 2, 8'hA5, 8'h3C, 1'b1);
    xfer(TGT, 1'b1, 2, 8'h96, 8'h5A, 1'b1);
    xfer(7'h17, 1'b0, 1, 8'h55, 8'h00, 1'b1);
    xfer(TGT, 1'b0, 1, 8'h11, 8'h00, 1'b0);
    xfer(TGT, 1'b1, 1, 8'hC3, 8'h00, 1'b1);
    // STOP four bits into a write byte
    start_c();
    write_byte({TGT, 1'b0}, ack);
    chk("partial_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    stop_c();
    chk("partial_oe", bus.o_sda_oe, 0);
    chk("partial_busy", bus.o_busy, 0);
    chk("partial_rx_drained", rx_exp.size(), 0);
    // reset while the target holds ACK
    start_c();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : TGT[i - 1]);
    cyc(4); m_sda = 1'b1; cyc(2);
    chk("ack_driven", bus.o_sda_oe, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("oe_after_rst", bus.o_sda_oe, 0);
    cyc(1); m_scl = 1'b1; cyc(8); m_scl = 1'b0;
    write_byte(8'h3A, ack);
    chk("ignored_after_rst", ack, 1);
    xfer(TGT, 1'b0, 1, 8'h7E, 8'h00, 1'b1);
    for (int t = 0; t < 16; t++) begin
      a = ($urandom_range(0, 1) != 0) ? TGT : 7'($urandom_range(0, 127));
      if (a == TGT && t[0]) a = 7'h43;
      xfer(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 8'($urandom), 8'($urandom),
           t == 15 || $urandom_range(0, 3) != 0);
    end
    cyc(20);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
